// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the R15 index and the lock FSM state encoding.
package rf_write_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int R15_IDX    = 15;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCK_A = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side handshake bundle for the two writeback sources (A: ALU, B: load).
// The master modport is the requester side and the slave modport is the arbiter.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              a_req;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_gnt;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_gnt;

  modport master (
    output a_req, a_lock, a_addr, a_data,
    output b_req, b_addr, b_data,
    input  a_gnt, b_gnt
  );

  modport slave (
    input  a_req, a_lock, a_addr, a_data,
    input  b_req, b_addr, b_data,
    output a_gnt, b_gnt
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-winner pointer; force_a hands A the
// bus outright (used while A holds a burst lock).
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic force_a,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (force_a) begin
        gnt_a = req_a;
      end else if (req_a && req_b) begin
        gnt_a = last_b;
        gnt_b = !last_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Pointer starts at B-last so A wins the first contended cycle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: picks one of two writeback sources per
// cycle, supports an A-side burst lock, and registers the winning write.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              clk,
  input  logic              rst_n,
  rf_write_arbiter_if.slave bus,
  output logic              rf_ld,
  output logic [ADDR_W-1:0] rf_c,
  output logic [DATA_W-1:0] rf_pc,
  output logic              pc_wr
);

  state_t            state;
  state_t            state_next;
  logic              a_gnt;
  logic              b_gnt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (bus.a_req),
    .req_b   (bus.b_req),
    .force_a (state == ST_LOCK_A),
    .gnt_a   (a_gnt),
    .gnt_b   (b_gnt)
  );

  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A dropping its request ends the burst even without an unlocked transfer
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (a_gnt && bus.a_lock) state_next = ST_LOCK_A;
      end
      ST_LOCK_A: begin
        if (!bus.a_req || (a_gnt && !bus.a_lock)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en   = a_gnt | b_gnt;
    wr_addr = bus.a_addr;
    wr_data = bus.a_data;
    if (b_gnt) begin
      wr_addr = bus.b_addr;
      wr_data = bus.b_data;
    end
  end

  // Address and data hold their previous values on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ld <= 1'b0;
      pc_wr <= 1'b0;
      rf_c  <= '0;
      rf_pc <= '0;
    end else begin
      rf_ld <= wr_en;
      pc_wr <= wr_en && (wr_addr == ADDR_W'(R15_IDX));
      if (wr_en) begin
        rf_c  <= wr_addr;
        rf_pc <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural arbitration model.
module tb_rf_write_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_ld;
  logic [3:0]  rf_c;
  logic [31:0] rf_pc;
  logic        pc_wr;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .rf_ld (rf_ld),
    .rf_c  (rf_c),
    .rf_pc (rf_pc),
    .pc_wr (pc_wr)
  );

  always #5 clk = ~clk;

  // Model state: who won last, whether A owns the port, and the expected write
  bit          m_locked = 1'b0;
  bit          m_a_last = 1'b0;
  bit          m_xa     = 1'b0;
  bit          m_xb     = 1'b0;
  logic        exp_ld   = 1'b0;
  logic        exp_pcwr = 1'b0;
  logic [3:0]  exp_c    = '0;
  logic [31:0] exp_pc   = '0;
  logic [1:0]  mg;
  logic [1:0]  cg;

  function automatic logic [1:0] model_grant();
    if (!rst_n) return 2'b00;
    if (m_locked) return {bus.a_req, 1'b0};
    if (bus.a_req && bus.b_req) return m_a_last ? 2'b01 : 2'b10;
    return {bus.a_req, bus.b_req};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 1'b0;
      m_a_last = 1'b0;
      m_xa     = 1'b0;
      m_xb     = 1'b0;
      exp_ld   = 1'b0;
      exp_pcwr = 1'b0;
      exp_c    = '0;
      exp_pc   = '0;
    end else begin
      mg     = model_grant();
      m_xa   = mg[1];
      m_xb   = mg[0];
      exp_ld = |mg;
      if (mg[1]) begin
        exp_c    = bus.a_addr;
        exp_pc   = bus.a_data;
        m_a_last = 1'b1;
        m_locked = bus.a_lock;
      end else if (mg[0]) begin
        exp_c    = bus.b_addr;
        exp_pc   = bus.b_data;
        m_a_last = 1'b0;
      end
      if (!bus.a_req) m_locked = 1'b0;
      exp_pcwr = exp_ld && (exp_c == 4'hF);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cg = model_grant();
    checkOutput("model a_gnt", 32'(bus.a_gnt), 32'(cg[1]));
    checkOutput("model b_gnt", 32'(bus.b_gnt), 32'(cg[0]));
    checkOutput("model rf_ld", 32'(rf_ld), 32'(exp_ld));
    checkOutput("model pc_wr", 32'(pc_wr), 32'(exp_pcwr));
    checkOutput("model rf_c",  32'(rf_c),  32'(exp_c));
    checkOutput("model rf_pc", rf_pc, exp_pc);
  end

  task automatic applyStimulus(input logic ar, input logic al, input logic [3:0] aa,
                               input logic [31:0] ad, input logic br,
                               input logic [3:0] ba, input logic [31:0] bd);
    bus.a_req  = ar;
    bus.a_lock = al;
    bus.a_addr = aa;
    bus.a_data = ad;
    bus.b_req  = br;
    bus.b_addr = ba;
    bus.b_data = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          c_seq[4] = '{1, 2, 1, 2};
  logic [3:0]  ga_pat   = 4'b0101;
  logic [2:0]  lk_pat   = 3'b011;

  initial begin
    applyStimulus(1, 0, 4'd3, 32'hAA, 0, 4'd0, 32'h0);
    #3;
    checkOutput("reset rf_ld", 32'(rf_ld), 32'd0);
    checkOutput("reset rf_c",  32'(rf_c),  32'd0);
    checkOutput("reset rf_pc", rf_pc,      32'd0);
    checkOutput("reset a_gnt", 32'(bus.a_gnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Single A write, presented as reset releases
    @(negedge clk);
    checkOutput("single a_gnt", 32'(bus.a_gnt), 32'd1);
    step();
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checkOutput("single rf_ld", 32'(rf_ld), 32'd1);
    checkOutput("single rf_c",  32'(rf_c),  32'd3);
    checkOutput("single rf_pc", rf_pc,      32'hAA);
    checkOutput("single pc_wr", 32'(pc_wr), 32'd0);
    step();

    // Contention straight after reset alternates A,B,A,B
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 4'd1, 32'h100, 1, 4'd2, 32'h200);
      @(negedge clk);
      checkOutput("rr a_gnt", 32'(bus.a_gnt), 32'(ga_pat[i]));
      checkOutput("rr b_gnt", 32'(bus.b_gnt), 32'(!ga_pat[i]));
      if (i > 0) checkOutput("rr rf_c", 32'(rf_c), 32'(c_seq[i-1]));
      step();
    end
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checkOutput("rr last rf_c", 32'(rf_c), 32'(c_seq[3]));
    step();

    // Locked burst of three A writes holds B off
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, lk_pat[i], 4'(4 + i), 32'h40 + 32'(i), 1, 4'd8, 32'h80);
      @(negedge clk);
      checkOutput("lock a_gnt", 32'(bus.a_gnt), 32'd1);
      checkOutput("lock b_gnt", 32'(bus.b_gnt), 32'd0);
      step();
    end
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 4'd8, 32'h80);
    @(negedge clk);
    checkOutput("unlock b_gnt", 32'(bus.b_gnt), 32'd1);
    checkOutput("lock rf_c",    32'(rf_c),      32'd6);
    step();
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checkOutput("unlock rf_c", 32'(rf_c), 32'd8);
    step();

    // R15 write raises pc_wr for one cycle
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 4'd15, 32'h1000);
    @(negedge clk);
    checkOutput("pc b_gnt", 32'(bus.b_gnt), 32'd1);
    step();
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checkOutput("pc pc_wr", 32'(pc_wr), 32'd1);
    checkOutput("pc rf_c",  32'(rf_c),  32'd15);
    checkOutput("pc rf_pc", rf_pc,      32'h1000);
    step();
    @(negedge clk);
    checkOutput("pc pulse end", 32'(pc_wr), 32'd0);
    step();

    // Same destination: winner first, loser's data lands last
    applyStimulus(1, 0, 4'd7, 32'h11, 1, 4'd7, 32'h22);
    @(negedge clk);
    checkOutput("same a_gnt", 32'(bus.a_gnt), 32'd1);
    step();
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 4'd7, 32'h22);
    @(negedge clk);
    checkOutput("same b_gnt",   32'(bus.b_gnt), 32'd1);
    checkOutput("same first",   rf_pc,          32'h11);
    step();
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(negedge clk);
    checkOutput("same final", rf_pc, 32'h22);
    step();

    // Reset mid-burst: async clear, pointer back to A-first, lock dropped
    applyStimulus(1, 1, 4'd9, 32'h99, 1, 4'd3, 32'h33);
    @(negedge clk);
    checkOutput("burst a_gnt", 32'(bus.a_gnt), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rf_ld", 32'(rf_ld),     32'd0);
    checkOutput("async a_gnt", 32'(bus.a_gnt), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset a_gnt", 32'(bus.a_gnt), 32'd1);
    checkOutput("post-reset b_gnt", 32'(bus.b_gnt), 32'd0);
    step();
    #2;
    rst_n = 1'b0;
    step();
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 4'd3, 32'h33);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("lock dropped b_gnt", 32'(bus.b_gnt), 32'd1);
    step();

    // Random traffic obeying the hold-until-granted handshake
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if (!(bus.a_req && !m_xa)) begin
        bus.a_req  = ($urandom_range(0, 3) != 0);
        bus.a_lock = ($urandom_range(0, 2) == 0);
        bus.a_addr = 4'($urandom_range(0, 15));
        bus.a_data = $urandom;
      end
      if (!(bus.b_req && !m_xb)) begin
        bus.b_req  = ($urandom_range(0, 3) != 0);
        bus.b_addr = 4'($urandom_range(0, 15));
        bus.b_data = $urandom;
      end
      step();
    end

    rst_n = 1'b1;
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: port clk, input, 1, rising-edge clock; port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port a_req, input, 1: requester A (ALU writeback) wants a write.
REQ-005 The block SHALL have port a_lock, input, 1: requester A requests exclusive multi-cycle ownership (block-load burst).
REQ-006 The block SHALL have port a_addr, input, ADDR_W: A destination register.
REQ-007 The block SHALL have port a_data, input, DATA_W: A write data.
REQ-008 The block SHALL have port a_gnt, output, 1: A's write accepted this cycle.
REQ-009 The block SHALL have ports b_req, b_addr and b_data as inputs, and b_gnt as an output, with the same widths and meanings for requester B (memory load writeback); B has no lock.
REQ-010 The block SHALL have port rf_ld, output, 1: register-file write enable (drives RF).
REQ-011 The block SHALL have port rf_c, output, ADDR_W: register-file write address (drives C).
REQ-012 The block SHALL have port rf_pc, output, DATA_W: register-file write data (drives PC).
REQ-013 The block SHALL have port pc_wr, output, 1: one-cycle pulse, the issued write targets R15.

Function
REQ-014 Handshake: a requester SHALL hold req, addr and data stable until it sees gnt high; a transfer occurs in a cycle where req and gnt are both high.
REQ-015 a_gnt/b_gnt SHALL be combinational from the current-cycle req, lock state and round-robin pointer; at most one gnt SHALL be high per cycle.
REQ-016 With only one req high (and no lock by the other side), that requester SHALL be granted in the same cycle.
REQ-017 With both req high in IDLE, the requester not granted most recently SHALL win; after reset, A wins first.
REQ-018 The round-robin pointer SHALL update only on a transfer, recording the winner.
REQ-019 The FSM SHALL have states IDLE and LOCK_A; reset state IDLE.
REQ-020 IDLE -> LOCK_A SHALL occur on an A transfer with a_lock=1; LOCK_A -> IDLE SHALL occur on an A transfer with a_lock=0, or on any cycle with a_req=0.
REQ-021 In LOCK_A, b_gnt SHALL be 0 and a_gnt SHALL equal a_req, regardless of the pointer.
REQ-022 The write outputs SHALL be registered: a transfer in cycle N SHALL give rf_ld=1, rf_c=addr and rf_pc=data in cycle N+1 (latency 1); with no transfer, rf_ld=0 in cycle N+1.
REQ-023 rf_c and rf_pc SHALL hold their last values when rf_ld=0.
REQ-024 pc_wr SHALL be high in cycle N+1 exactly when the cycle-N transfer had addr = all ones (R15).
REQ-025 When both requesters target the same address in the same cycle, the winner's write SHALL issue first and the loser's SHALL issue in a later cycle, so the loser's data is final.
REQ-026 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-027 While rst_n=0, the block SHALL immediately set: rf_ld=0, pc_wr=0, rf_c=0, rf_pc=0, FSM=IDLE, pointer=B-last (so A wins first); a_gnt=0 and b_gnt=0.
REQ-028 A reset asserted mid-burst in LOCK_A SHALL drop the lock; the first post-reset arbitration SHALL follow REQ-017.
REQ-029 Transfers presented in the cycle rst_n deasserts SHALL be arbitrated normally.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding (IDLE, LOCK_A), DATA_W/ADDR_W defaults and the R15 index constant.
REQ-031 One sub-module, rr_arb2 (2-way round-robin grant with pointer), is natural; everything else SHALL be in rf_write_arbiter.

Verification
REQ-032 Single A: a_req=1, a_addr=3, a_data=0x0000_00AA -> a_gnt=1 same cycle; next cycle rf_ld=1, rf_c=3, rf_pc=0xAA, pc_wr=0.
REQ-033 Contention: both req held 4 cycles after reset (A addr 1, B addr 2) -> grants A,B,A,B; rf_c sequence 1,2,1,2 each one cycle later.
REQ-034 Lock: A issues 3 locked writes (addr 4,5,6; a_lock=1,1,0) while b_req=1 -> b_gnt=0 for those 3 cycles; B is granted in the 4th cycle.
REQ-035 PC write: b_addr=15, b_data=0x0000_1000 -> next cycle pc_wr=1, rf_c=15, rf_pc=0x1000.
REQ-036 Same address: A and B both addr 7 (A=0x11, B=0x22), A wins -> rf_pc 0x11 then 0x22 on consecutive cycles.
REQ-037 Reset in LOCK_A: pull rst_n low mid-burst -> rf_ld=0 asynchronously; after release, with both req high, A is granted first and the FSM is IDLE.
